stepper_axis: RTL and testbench
===============================

# stepper_axis

Parametrised single-axis stepper motor controller: it replaces the fixed divider plus step-driver pair with one block that adds commanded step counts, full/half-step modes, a trapezoidal speed ramp, pause/abort and position tracking. It sits between the slicing controller (the command source) and the motor coil pins on GPIO. It is instantiated once per axis: one instance for the cutter and one for the track.

## Interface
- PERIOD_MAX, 5_000_000: step period at start and stop, in clk cycles. Must be ≥ PERIOD_MIN.
- PERIOD_MIN, 500_000: cruise step period in clk cycles. Must be ≥ 2.
- RAMP_STEP, 50_000: period change per step while accelerating or decelerating. Must be ≥ 1.
- POS_W, 16: width of the step-count command.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst_n  in  1  asynchronous active-low reset (KEY[0]).
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_steps  in  POS_W  number of steps to move; 0 is legal.
- cmd_dir  in  1  direction: 1 = forward (pos +1, phase +), 0 = back.
- half_step  in  1  step mode, sampled at acceptance: 1 = 8-state half-step, 0 = 4-state two-coil full-step.
- pause_i  in  1  level input; freezes motion while high.
- abort_i  in  1  single-cycle or level input; ends the move.
- coil_o  out  4  registered coil drive.
- busy_o  out  1  move in progress (including while paused).
- done_o  out  1  one-cycle pulse at move end, whether completed or aborted.
- aborted_o  out  1  registered flag: last move ended by abort.
- pos_o  out  POS_W+1  signed absolute position in steps; wraps two's-complement.
- remaining_o  out  POS_W  steps still to go.

## Operation
- States: IDLE, RUN, PAUSED, FINISH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid (acceptance edge T): latch dir, mode and remaining=cmd_steps; set period p=PERIOD_MAX, ramp_cnt=0, tick=0; clear aborted_o.
  - In full-step mode, force the phase index odd (idx|=1). This updates coil_o but does not change pos_o.
  - Go to RUN, or to FINISH if cmd_steps==0.
- Phase table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Half-step: idx ±1 per step.
  - Full-step: idx ±2 per step (odd entries only).
  - idx wraps mod 8.
- RUN:
  - tick increments each cycle. When tick==p-1, a step event occurs: tick←0, idx advances by dir, pos ±1, remaining-1.
  - After each step event, with rem = remaining after decrement:
    - If rem ≤ ramp_cnt: p←min(p+RAMP_STEP, PERIOD_MAX) and ramp_cnt-1 (saturates at 0).
    - Else if p > PERIOD_MIN: p←max(p−RAMP_STEP, PERIOD_MIN) and ramp_cnt+1.
    - Else: p unchanged (cruise).
  - Arithmetic is done one bit wider than p so the saturation cannot wrap.
  - When rem==0, go to FINISH.
- PAUSED:
  - Entered from RUN while pause_i=1. tick, p and all position state freeze; coil_o holds.
  - Returns to RUN when pause_i=0 and resumes the partial tick.
- abort_i (RUN or PAUSED) has priority over pause and over a same-cycle step event. The step is not taken; go to FINISH with aborted_o=1, and remaining_o keeps the untaken count.
- FINISH (1 cycle): done_o=1, then go to IDLE. cmd_ready=0 during FINISH.
- Commands offered while busy are ignored (cmd_ready=0). abort_i in IDLE is ignored.
- Reset mid-move returns immediately to IDLE. All outputs return to reset values; position is lost.

## Timing
- Reset values: cmd_ready=1; coil_o=0000; busy_o=0; done_o=0; aborted_o=0; pos_o=0; remaining_o=0; idx=0.
- busy_o rises at T+1.
- The first step's coil/pos/remaining update is registered PERIOD_MAX cycles after T.
- Successive updates are spaced by the period in force for that step.
- done_o is high during the cycle after the last step's update. busy_o falls and cmd_ready rises on the same edge done_o falls.
- A command may be accepted the cycle after done_o.
- With cmd_steps=0: done_o is high during T+1.
- With abort: done_o is high in the cycle after abort_i is sampled.

## Configuration
- STEPPER_IDLE_RELEASE_EN:
  - Defined: coil_o is driven 0000 whenever the state is IDLE (coils de-energised, no holding torque). idx is still retained for the next move.
  - Undefined: coil_o holds the last phase pattern in IDLE (holding torque). It is 0000 only between reset and the first accepted command.

## Test plan
- PERIOD_MAX=6, PERIOD_MIN=2, RAMP_STEP=2, half-step, dir=1, 10 steps from reset:
  - Step intervals 6,4,2,2,2,2,2,2,4,6 cycles (total 32).
  - coil_o runs 1000→1100, 0100, 0110, 0010, 0011, 0001, 1001, 1000, 1100, 0100.
  - pos_o=10, one done_o pulse.
- Full-step, dir=0, 3 steps starting from idx=2:
  - At acceptance coil_o=0110 (idx 3), then 1100, 1001, 0011.
  - pos_o decreases by 3.
- pause_i high for 20 cycles mid-run:
  - coil_o/pos_o frozen; busy_o stays 1.
  - Total move time grows by exactly 20 cycles.
- abort_i on the same cycle as a step event in a 10-step move, after step 4:
  - Step 5 is not taken; remaining_o=6; aborted_o=1; done_o pulses once.
- cmd_steps=0 → done_o pulse at T+1; coil_o unchanged; pos_o unchanged.
- Second cmd_valid held during a move → ignored; accepted only when cmd_ready=1.
- With STEPPER_IDLE_RELEASE_EN: coil_o=0000 the cycle after done_o.
- Without STEPPER_IDLE_RELEASE_EN: the last pattern is held.

Source files
------------

// File: rtl/stepper_axis.sv
// stepper_axis: single-axis stepper motor controller.
// Accepts a step-count command, drives a 4-coil phase pattern in full- or
// half-step mode with a trapezoidal speed ramp, supports pause and abort,
// and tracks absolute position.
// Optional feature macro: STEPPER_IDLE_RELEASE_EN (de-energise coils in IDLE).
//
// Handshake: a command transfers on a rising clk edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high only in IDLE. Offers made while cmd_ready=0
// are ignored, and the command source may hold or drop cmd_valid freely.
module stepper_axis #(
  parameter int PERIOD_MAX = 5_000_000,
  parameter int PERIOD_MIN = 500_000,
  parameter int RAMP_STEP  = 50_000,
  parameter int POS_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             half_step,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [3:0]       coil_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [POS_W:0]   pos_o,
  output logic [POS_W-1:0] remaining_o
);

  // Period and tick counters must hold PERIOD_MAX; ramp arithmetic uses one
  // extra bit so that adding or subtracting RAMP_STEP cannot wrap.
  localparam int PW = $clog2(PERIOD_MAX + 1);
  localparam logic [PW:0] P_MAX_W = (PW+1)'(PERIOD_MAX);
  localparam logic [PW:0] P_MIN_W = (PW+1)'(PERIOD_MIN);
  localparam logic [PW:0] RAMP_W  = (PW+1)'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, FINISH} state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic [POS_W-1:0] rem_q, rem_d;
  logic [POS_W-1:0] ramp_q, ramp_d;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    tick_q, tick_d;
  logic [2:0]       idx_q, idx_d;
  logic [POS_W:0]   pos_q, pos_d;
  logic [3:0]       coil_q, coil_d;
  logic             aborted_q, aborted_d;
  logic [2:0]       inc;
  logic [PW:0]      sum_w;
  logic [PW:0]      diff_w;

  // Coil pattern for each phase index; odd entries drive two coils.
  function automatic logic [3:0] phase(input logic [2:0] i);
    logic [3:0] c;
    case (i)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1100;
      3'd2:    c = 4'b0100;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b0011;
      3'd6:    c = 4'b0001;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

  // State and datapath registers; reset loses position and de-energises coils.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      rem_q     <= '0;
      ramp_q    <= '0;
      p_q       <= '0;
      tick_q    <= '0;
      idx_q     <= '0;
      pos_q     <= '0;
      coil_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      rem_q     <= rem_d;
      ramp_q    <= ramp_d;
      p_q       <= p_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      coil_q    <= coil_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic: command acceptance, step timing, ramp and abort/pause.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    half_d    = half_q;
    rem_d     = rem_q;
    ramp_d    = ramp_q;
    p_d       = p_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    coil_d    = coil_q;
    aborted_d = aborted_q;
    inc       = half_q ? 3'd1 : 3'd2;
    sum_w     = {1'b0, p_q} + RAMP_W;
    diff_w    = {1'b0, p_q} - RAMP_W;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d     = cmd_dir;
          half_d    = half_step;
          rem_d     = cmd_steps;
          p_d       = P_MAX_W[PW-1:0];
          ramp_d    = '0;
          tick_d    = '0;
          aborted_d = 1'b0;
          if (cmd_steps == '0) begin
            // Nothing to move: leave the phase and coils untouched.
            state_d = FINISH;
          end else begin
            // Full-step only uses the two-coil (odd) entries.
            idx_d   = half_step ? idx_q : (idx_q | 3'd1);
            coil_d  = phase(idx_d);
            state_d = RUN;
          end
        end
      end

      RUN, PAUSED: begin
        if (abort_i) begin
          // Abort wins over pause and over a step due this cycle.
          state_d   = FINISH;
          aborted_d = 1'b1;
        end else if (pause_i) begin
          // Everything freezes, including the partial tick.
          state_d = PAUSED;
        end else begin
          state_d = RUN;
          if (tick_q == p_q - PW'(1)) begin
            tick_d = '0;
            idx_d  = dir_q ? (idx_q + inc) : (idx_q - inc);
            pos_d  = dir_q ? (pos_q + (POS_W+1)'(1)) : (pos_q - (POS_W+1)'(1));
            rem_d  = rem_q - POS_W'(1);
            coil_d = phase(idx_d);
            if (rem_d <= ramp_q) begin
              // Close enough to the end: slow down by one ramp increment.
              p_d = (sum_w > P_MAX_W) ? P_MAX_W[PW-1:0] : sum_w[PW-1:0];
              if (ramp_q != '0) ramp_d = ramp_q - POS_W'(1);
            end else if ({1'b0, p_q} > P_MIN_W) begin
              // Still accelerating toward cruise speed.
              p_d = (({1'b0, p_q} < RAMP_W) || (diff_w < P_MIN_W)) ?
                    P_MIN_W[PW-1:0] : diff_w[PW-1:0];
              ramp_d = ramp_q + POS_W'(1);
            end
            if (rem_d == '0) state_d = FINISH;
          end else begin
            tick_d = tick_q + PW'(1);
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase

`ifdef STEPPER_IDLE_RELEASE_EN
    // Coils released whenever idle; idx is kept for the next move.
    if (state_d == IDLE) coil_d = 4'b0000;
`endif
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FINISH);
  assign coil_o      = coil_q;
  assign aborted_o   = aborted_q;
  assign pos_o       = pos_q;
  assign remaining_o = rem_q;

endmodule

// File: tb/tb_stepper_axis.sv
// tb_stepper_axis: scoreboard bench for stepper_axis with small ramp
// parameters. A driver issues moves and pushes the predicted output events
// (value changes and done pulses, each stamped with its expected cycle) into
// exp_q; a monitor pops and compares whenever the outputs change or done_o
// is high.
module tb_stepper_axis;

  localparam int PMAX  = 6;
  localparam int PMIN  = 2;
  localparam int RS    = 2;
  localparam int POS_W = 8;
  localparam int CW    = 20;
  localparam int REC_W = 2 + 4 + (POS_W + 1) + POS_W + CW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_steps = '0;
  logic             cmd_dir = 1'b0;
  logic             half_step = 1'b0;
  logic             pause_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [3:0]       coil_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [POS_W:0]   pos_o;
  logic [POS_W-1:0] remaining_o;

  stepper_axis #(
    .PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN), .RAMP_STEP(RS), .POS_W(POS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .half_step(half_step),
    .pause_i(pause_i), .abort_i(abort_i), .coil_o(coil_o), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o), .pos_o(pos_o),
    .remaining_o(remaining_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [REC_W-1:0] exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  mon_on = 1'b0;

  // Reference model state (behavioural, in plain integers).
  logic [3:0] tbl [8];
  int         m_idx = 0;
  int         m_pos = 0;
  int         m_rem = 0;
  bit         m_ab = 1'b0;
  logic [3:0] o_coil = 4'b0000;

  function automatic logic [REC_W-1:0] mk(input bit d, input bit a,
      input logic [3:0] c, input int pos, input int rem, input int t);
    return {d, a, c, (POS_W+1)'(pos), POS_W'(rem), CW'(t)};
  endfunction

  // Cycle offset (from acceptance) of step k of an n-step move, no pause.
  function automatic int nominal_time(input int n, input int k);
    int p, ramp, t, rem;
    p = PMAX; ramp = 0; t = 0; rem = n;
    for (int i = 1; i <= k; i++) begin
      t += p;
      rem -= 1;
      if (rem <= ramp) begin
        p = (p + RS > PMAX) ? PMAX : p + RS;
        if (ramp > 0) ramp -= 1;
      end else if (p > PMIN) begin
        p = (p - RS < PMIN) ? PMIN : p - RS;
        ramp += 1;
      end
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [3:0]       pc;
    logic [POS_W:0]   pp;
    logic [POS_W-1:0] pr;
    logic [REC_W-1:0] act, e;
    pc = '0; pp = '0; pr = '0;
    forever begin
      @(negedge clk);
      if (mon_on && (coil_o !== pc || pos_o !== pp || remaining_o !== pr || done_o === 1'b1)) begin
        act = {done_o, aborted_o, coil_o, pos_o, remaining_o, CW'(cyc)};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got %0h with none expected", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL output_event: got %0h required %0h", act, e);
          end
        end
      end
      pc = coil_o; pp = pos_o; pr = remaining_o;
    end
  end

  // ---------------- driver ----------------
  // pause_at/abort_at are edge offsets from acceptance (<=0 means unused).
  task automatic run_move(input int n, input bit dir, input bit half,
                          input int pause_at, input int pause_len,
                          input int abort_at, input bit hold);
    int T, D, r, g, inc, t, act_t;
    logic [3:0] old_coil;
    int old_rem;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (cmd_ready !== 1'b1) begin
      check("ready_timeout", 64'(cmd_ready), 64'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_steps = POS_W'(n);
    cmd_dir   = dir;
    half_step = half;
    T = cyc + 1;

    // Predict the move.
    old_coil = o_coil;
    old_rem  = m_rem;
    m_ab  = 1'b0;
    m_rem = n;
    if (n == 0) begin
      exp_q.push_back(mk(1'b1, 1'b0, o_coil, m_pos, 0, T));
      D = T;
    end else begin
      if (!half) m_idx = m_idx | 1;
      o_coil = tbl[m_idx];
      if (o_coil != old_coil || n != old_rem)
        exp_q.push_back(mk(1'b0, 1'b0, o_coil, m_pos, m_rem, T));
      inc = half ? 1 : 2;
      D = T;
      for (int k = 1; k <= n; k++) begin
        t = nominal_time(n, k);
        act_t = t + ((pause_at > 0 && t >= pause_at) ? pause_len : 0);
        if (abort_at > 0 && act_t >= abort_at) begin
          m_ab = 1'b1;
          break;
        end
        m_idx = (m_idx + (dir ? inc : 8 - inc)) % 8;
        m_pos = dir ? m_pos + 1 : m_pos - 1;
        m_rem = m_rem - 1;
        o_coil = tbl[m_idx];
        exp_q.push_back(mk(m_rem == 0, 1'b0, o_coil, m_pos, m_rem, T + act_t));
        D = T + act_t;
      end
      if (m_ab) begin
        exp_q.push_back(mk(1'b1, 1'b1, o_coil, m_pos, m_rem, T + abort_at));
        D = T + abort_at;
      end
    end
`ifdef STEPPER_IDLE_RELEASE_EN
    if (o_coil != 4'b0000) begin
      exp_q.push_back(mk(1'b0, m_ab, 4'b0000, m_pos, m_rem, D + 1));
      o_coil = 4'b0000;
    end
`endif

    // Drive until the block is back in IDLE.
    while (cyc < D + 1) begin
      @(negedge clk);
      r = cyc - T;
      if (!hold || cyc >= D) begin
        cmd_valid = 1'b0;
      end else begin
        cmd_steps = POS_W'($urandom_range(1, 255));
        cmd_dir   = 1'($urandom_range(0, 1));
        half_step = 1'($urandom_range(0, 1));
      end
      pause_i = (pause_at > 0 && r + 1 >= pause_at && r + 1 < pause_at + pause_len);
      abort_i = (abort_at > 0 && r + 1 == abort_at);
    end
    cmd_valid = 1'b0;
    pause_i   = 1'b0;
    abort_i   = 1'b0;
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_ready", 64'(cmd_ready), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, sel, L, pa, pl, aa;
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_coil", 64'(coil_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_aborted", 64'(aborted_o), 64'd0);
    check("rst_pos", 64'(pos_o), 64'd0);
    check("rst_remaining", 64'(remaining_o), 64'd0);
    mon_on = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp profile, half-step forward, 10 steps from reset.
    run_move(10, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    check("pos_after_ramp", 64'(pos_o), 64'd10);
    // Full-step backward from idx 2.
    run_move(3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    check("pos_after_full", 64'(pos_o), 64'd7);
    // Pause for 20 cycles mid-run.
    run_move(10, 1'b1, 1'b1, 9, 20, 0, 1'b0);
    // Abort on the cycle step 5 would be taken.
    run_move(10, 1'b1, 1'b1, 0, 0, nominal_time(10, 5), 1'b0);
    check("abort_remaining", 64'(remaining_o), 64'd6);
    check("abort_flag", 64'(aborted_o), 64'd1);
    // Zero-step command.
    run_move(0, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    check("zero_clears_abort", 64'(aborted_o), 64'd0);
    // Command held valid while busy must be ignored.
    run_move(5, 1'b0, 1'b1, 0, 0, 0, 1'b1);

    // Randomised moves.
    for (int i = 0; i < 30; i++) begin
      n   = $urandom_range(0, 12);
      sel = $urandom_range(0, 3);
      pa = 0; pl = 0; aa = 0;
      if (n > 0) begin
        L = nominal_time(n, n);
        if (sel == 0) begin
          pa = $urandom_range(1, L);
          pl = $urandom_range(1, 8);
        end else if (sel == 1) begin
          aa = $urandom_range(1, L);
        end
      end
      run_move(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pa, pl, aa,
               1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
